// File: rtl/rv32i_decode_execute_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, control codes, NOP.
package rv32i_decode_execute_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_AUIPC  = 7'b0010111,
    OP_LUI    = 7'b0110111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_R_TYPE = 3'b000,
    ALU_I_TYPE = 3'b001,
    ALU_BRANCH = 3'b010,
    ALU_JUMP   = 3'b011,
    ALU_LOAD   = 3'b100,
    ALU_STORE  = 3'b101,
    ALU_UPPER  = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JAL    = 2'b10,
    NPC_JALR   = 2'b11
  } next_pc_sel_t;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'b00,
    A_SEL_PC   = 2'b01,
    A_SEL_PC4  = 2'b10,
    A_SEL_ZERO = 2'b11
  } a_sel_t;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_t;

  typedef enum logic [1:0] {
    EXT_I = 2'b00,
    EXT_U = 2'b01,
    EXT_S = 2'b10
  } ext_sel_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv32i_decode_execute_regfile32.sv
// 32-entry register file: async active-low clear, x0 hardwired, write-through reads.
module regfile32 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic                  wr_en;

  // Writes are suppressed for x0 and while reset is held low.
  assign wr_en = write && (write_reg != 5'd0) && reset;

  // Register array: cleared asynchronously, written on the rising clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Combinational reads with bypass of a same-cycle write.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != 5'd0)
      read_data1 = (wr_en && write_reg == read_reg1) ? write_data : regs[read_reg1];
    if (read_reg2 != 5'd0)
      read_data2 = (wr_en && write_reg == read_reg2) ? write_data : regs[read_reg2];
  end

endmodule

// File: rtl/rv32i_decode_execute.sv
// RV32I ID-stage decode/control/immediates plus EX-stage ALU, branch and JALR logic.
module rv32i_decode_execute
  import rv32i_decode_execute_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  // ID side
  input  logic [31:0]             instruction,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic                    write,
  input  logic [4:0]              write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [6:0]              opcode,
  output logic [2:0]              funct3,
  output logic [6:0]              funct7,
  output logic [4:0]              rd,
  output logic [DATA_WIDTH-1:0]   rs1_data,
  output logic [DATA_WIDTH-1:0]   rs2_data,
  output logic [DATA_WIDTH-1:0]   extend_imm,
  output logic [ADDRESS_BITS-1:0] branch_target,
  output logic [ADDRESS_BITS-1:0] JAL_target,
  output logic                    branch_op,
  output logic                    memRead,
  output logic                    memtoReg,
  output logic                    memWrite,
  output logic                    regWrite,
  output logic [2:0]              ALUOp,
  output logic [1:0]              next_PC_sel,
  output logic [1:0]              operand_A_sel,
  output logic                    operand_B_sel,
  output logic [1:0]              extend_sel,
  // EX side
  input  logic [2:0]              ALU_Operation,
  input  logic [2:0]              ex_funct3,
  input  logic [6:0]              ex_funct7,
  input  logic                    ex_branch_op,
  input  logic [ADDRESS_BITS-1:0] ex_PC,
  input  logic [1:0]              ALU_ASrc,
  input  logic                    ALU_BSrc,
  input  logic [DATA_WIDTH-1:0]   regRead_1,
  input  logic [DATA_WIDTH-1:0]   regRead_2,
  input  logic [DATA_WIDTH-1:0]   extend,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic                    zero,
  output logic                    branch,
  output logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    report
);

  localparam int PAD = DATA_WIDTH - ADDRESS_BITS;

  // ---------------- Decode ----------------
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rd     = instruction[11:7];

  regfile32 #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (instruction[19:15]),
    .read_reg2  (instruction[24:20]),
    .read_data1 (rs1_data),
    .read_data2 (rs2_data)
  );

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  // Immediate format selected by the control decode.
  always_comb begin
    extend_imm = '0;
    case (extend_sel)
      EXT_I:   extend_imm = imm_i;
      EXT_U:   extend_imm = imm_u;
      EXT_S:   extend_imm = imm_s;
      default: extend_imm = '0;
    endcase
  end

  // Targets wrap modulo 2^ADDRESS_BITS by truncating the 32-bit sum.
  logic [DATA_WIDTH-1:0] pc_ext, br_sum, jal_sum;
  assign pc_ext        = {{PAD{1'b0}}, PC};
  assign br_sum        = pc_ext + imm_b;
  assign jal_sum       = pc_ext + imm_j;
  assign branch_target = br_sum[ADDRESS_BITS-1:0];
  assign JAL_target    = jal_sum[ADDRESS_BITS-1:0];

  // Main control: one row per opcode, everything zero for unknown opcodes.
  always_comb begin
    branch_op     = 1'b0;
    memRead       = 1'b0;
    memtoReg      = 1'b0;
    memWrite      = 1'b0;
    regWrite      = 1'b0;
    ALUOp         = 3'b000;
    next_PC_sel   = 2'b00;
    operand_A_sel = 2'b00;
    operand_B_sel = 1'b0;
    extend_sel    = 2'b00;
    case (opcode)
      OP_R: begin
        ALUOp = ALU_R_TYPE; regWrite = 1'b1;
      end
      OP_I_ALU: begin
        ALUOp = ALU_I_TYPE; operand_B_sel = B_SEL_IMM; extend_sel = EXT_I; regWrite = 1'b1;
      end
      OP_LOAD: begin
        ALUOp = ALU_LOAD; operand_B_sel = B_SEL_IMM; extend_sel = EXT_I;
        memRead = 1'b1; memtoReg = 1'b1; regWrite = 1'b1;
      end
      OP_STORE: begin
        ALUOp = ALU_STORE; operand_B_sel = B_SEL_IMM; extend_sel = EXT_S; memWrite = 1'b1;
      end
      OP_BRANCH: begin
        ALUOp = ALU_BRANCH; next_PC_sel = NPC_BRANCH; branch_op = 1'b1;
      end
      OP_JALR: begin
        ALUOp = ALU_JUMP; next_PC_sel = NPC_JALR; operand_A_sel = A_SEL_PC4;
        operand_B_sel = B_SEL_IMM; extend_sel = EXT_I; regWrite = 1'b1;
      end
      OP_JAL: begin
        ALUOp = ALU_JUMP; next_PC_sel = NPC_JAL; operand_A_sel = A_SEL_PC4; regWrite = 1'b1;
      end
      OP_AUIPC: begin
        ALUOp = ALU_UPPER; operand_A_sel = A_SEL_PC; operand_B_sel = B_SEL_IMM;
        extend_sel = EXT_U; regWrite = 1'b1;
      end
      OP_LUI: begin
        ALUOp = ALU_UPPER; operand_A_sel = A_SEL_ZERO; operand_B_sel = B_SEL_IMM;
        extend_sel = EXT_U; regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Execute ----------------
  logic [DATA_WIDTH-1:0] op_a, op_b, ex_pc_ext;
  assign ex_pc_ext = {{PAD{1'b0}}, ex_PC};

  // Operand muxes.
  always_comb begin
    op_a = '0;
    case (ALU_ASrc)
      A_SEL_RS1: op_a = regRead_1;
      A_SEL_PC:  op_a = ex_pc_ext;
      A_SEL_PC4: op_a = ex_pc_ext + 32'd4;
      default:   op_a = '0;
    endcase
    op_b = ALU_BSrc ? extend : regRead_2;
  end

  // Comparison outcome for branches; unsupported funct3 never takes.
  logic outcome;
  always_comb begin
    outcome = 1'b0;
    case (ex_funct3)
      3'b000:  outcome = (op_a == op_b);
      3'b001:  outcome = (op_a != op_b);
      3'b100:  outcome = ($signed(op_a) <  $signed(op_b));
      3'b101:  outcome = ($signed(op_a) >= $signed(op_b));
      3'b110:  outcome = (op_a <  op_b);
      3'b111:  outcome = (op_a >= op_b);
      default: outcome = 1'b0;
    endcase
  end

  // ALU: funct3-decoded ops for R/I classes, add for memory/upper, pass for jumps.
  always_comb begin
    ALU_result = '0;
    case (ALU_Operation)
      ALU_R_TYPE, ALU_I_TYPE: begin
        case (ex_funct3)
          3'b000: ALU_result = (ALU_Operation == ALU_R_TYPE && ex_funct7[5])
                               ? op_a - op_b : op_a + op_b;
          3'b001: ALU_result = op_a << op_b[4:0];
          3'b010: ALU_result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          3'b011: ALU_result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
          3'b100: ALU_result = op_a ^ op_b;
          3'b101: ALU_result = ex_funct7[5] ? DATA_WIDTH'($signed(op_a) >>> op_b[4:0])
                                            : op_a >> op_b[4:0];
          3'b110: ALU_result = op_a | op_b;
          default: ALU_result = op_a & op_b;
        endcase
      end
      ALU_BRANCH:                     ALU_result = {{(DATA_WIDTH-1){1'b0}}, outcome};
      ALU_JUMP:                       ALU_result = op_a;
      ALU_LOAD, ALU_STORE, ALU_UPPER: ALU_result = op_a + op_b;
      default:                        ALU_result = '0;
    endcase
  end

  assign zero   = (ALU_result == '0);
  assign branch = ex_branch_op & outcome;

  logic [DATA_WIDTH-1:0] jalr_sum;
  assign jalr_sum    = regRead_1 + extend;
  assign JALR_target = {jalr_sum[ADDRESS_BITS-1:1], 1'b0};

  // Statistics reporting and CORE only matter to simulation models.
  logic unused_bits;
  assign unused_bits = ^{report, (CORE != 0), ex_funct7[6], ex_funct7[4:0],
                         br_sum[DATA_WIDTH-1:ADDRESS_BITS], jal_sum[DATA_WIDTH-1:ADDRESS_BITS],
                         jalr_sum[DATA_WIDTH-1:ADDRESS_BITS], jalr_sum[0]};

endmodule

// File: tb/tb_rv32i_decode_execute.sv
module tb_rv32i_decode_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [19:0] PC;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, extend_imm;
  logic [19:0] branch_target, JAL_target;
  logic        branch_op, memRead, memtoReg, memWrite, regWrite;
  logic [2:0]  ALUOp;
  logic [1:0]  next_PC_sel, operand_A_sel, extend_sel;
  logic        operand_B_sel;
  logic [2:0]  ALU_Operation, ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_branch_op;
  logic [19:0] ex_PC;
  logic [1:0]  ALU_ASrc;
  logic        ALU_BSrc;
  logic [31:0] regRead_1, regRead_2, extend, ALU_result;
  logic        zero, branch;
  logic [19:0] JALR_target;
  logic        report;

  int tests = 0;
  int fails = 0;

  rv32i_decode_execute #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .PC(PC),
    .write(write), .write_reg(write_reg), .write_data(write_data),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .extend_imm(extend_imm),
    .branch_target(branch_target), .JAL_target(JAL_target),
    .branch_op(branch_op), .memRead(memRead), .memtoReg(memtoReg),
    .memWrite(memWrite), .regWrite(regWrite), .ALUOp(ALUOp),
    .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel),
    .operand_B_sel(operand_B_sel), .extend_sel(extend_sel),
    .ALU_Operation(ALU_Operation), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_branch_op(ex_branch_op), .ex_PC(ex_PC), .ALU_ASrc(ALU_ASrc),
    .ALU_BSrc(ALU_BSrc), .regRead_1(regRead_1), .regRead_2(regRead_2),
    .extend(extend), .ALU_result(ALU_result), .zero(zero), .branch(branch),
    .JALR_target(JALR_target), .report(report)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [1:0] asrc, input logic bsrc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    ALU_Operation = op; ex_funct3 = f3; ex_funct7 = f7;
    ALU_ASrc = asrc; ALU_BSrc = bsrc;
    regRead_1 = a; regRead_2 = b; extend = imm;
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; write_reg = '0; write_data = '0;
    instruction = 32'h0002_8093;   // addi x1,x5,0 : rs1 = x5
    PC = '0; report = 1'b0;
    ALU_Operation = '0; ex_funct3 = '0; ex_funct7 = '0; ex_branch_op = 1'b0;
    ex_PC = '0; ALU_ASrc = '0; ALU_BSrc = 1'b0;
    regRead_1 = '0; regRead_2 = '0; extend = '0;

    // Reset state
    #12;
    check("reset_x5", rs1_data, 32'h0);
    @(negedge clock); reset = 1'b1; #1;
    check("after_reset_x5", rs1_data, 32'h0);

    // Write x5 = 0x1234: bypass in same cycle, stored after edge
    @(negedge clock); write = 1'b1; write_reg = 5'd5; write_data = 32'h1234; #1;
    check("bypass_x5", rs1_data, 32'h1234);
    @(negedge clock); write = 1'b0; #1;
    check("stored_x5", rs1_data, 32'h1234);

    // Write x0 = 7 never sticks
    instruction = 32'h00A0_0093;   // addi x1,x0,10
    @(negedge clock); write = 1'b1; write_reg = 5'd0; write_data = 32'h7; #1;
    check("x0_bypass", rs1_data, 32'h0);
    @(negedge clock); write = 1'b0; #1;
    check("x0_stored", rs1_data, 32'h0);

    // addi decode
    check("addi_opcode", {25'b0, opcode}, 32'h13);
    check("addi_rd", {27'b0, rd}, 32'd1);
    check("addi_ALUOp", {29'b0, ALUOp}, 32'd1);
    check("addi_Bsel", {31'b0, operand_B_sel}, 32'd1);
    check("addi_regWrite", {31'b0, regWrite}, 32'd1);
    check("addi_imm", extend_imm, 32'd10);
    check("addi_memRead", {31'b0, memRead}, 32'd0);

    // addi execute
    set_ex(3'b001, 3'b000, 7'h00, 2'b00, 1'b1, 32'd0, 32'd0, 32'd10); #1;
    check("addi_result", ALU_result, 32'd10);
    check("addi_zero", {31'b0, zero}, 32'd0);

    // sub / sra / srl / I-type ignores funct7 on add
    set_ex(3'b000, 3'b000, 7'h20, 2'b00, 1'b0, 32'd5, 32'd7, 32'd0); #1;
    check("sub", ALU_result, 32'hFFFF_FFFE);
    set_ex(3'b001, 3'b000, 7'h20, 2'b00, 1'b0, 32'd5, 32'd7, 32'd0); #1;
    check("itype_add_not_sub", ALU_result, 32'd12);
    set_ex(3'b000, 3'b101, 7'h20, 2'b00, 1'b0, 32'h8000_0000, 32'd4, 32'd0); #1;
    check("sra", ALU_result, 32'hF800_0000);
    set_ex(3'b000, 3'b101, 7'h00, 2'b00, 1'b0, 32'h8000_0000, 32'd4, 32'd0); #1;
    check("srl", ALU_result, 32'h0800_0000);
    set_ex(3'b000, 3'b000, 7'h20, 2'b00, 1'b0, 32'd9, 32'd9, 32'd0); #1;
    check("sub_zero_flag", {31'b0, zero}, 32'd1);

    // Branch comparisons
    ex_branch_op = 1'b1;
    set_ex(3'b010, 3'b100, 7'h00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0); #1;
    check("blt_branch", {31'b0, branch}, 32'd1);
    check("blt_result", ALU_result, 32'd1);
    ex_funct3 = 3'b110; #1;
    check("bltu_branch", {31'b0, branch}, 32'd0);
    ex_funct3 = 3'b010; #1;
    check("bad_f3_branch", {31'b0, branch}, 32'd0);
    ex_funct3 = 3'b100; ex_branch_op = 1'b0; #1;
    check("no_branch_op", {31'b0, branch}, 32'd0);

    // Branch decode: beq x0,x0,+8 at 0x100 and -4 at 0 (wraps)
    instruction = 32'h0000_0463; PC = 20'h00100; #1;
    check("beq_target", {12'b0, branch_target}, 32'h108);
    check("beq_npc", {30'b0, next_PC_sel}, 32'd1);
    check("beq_branch_op", {31'b0, branch_op}, 32'd1);
    instruction = 32'hFE00_0EE3; PC = 20'h00000; #1;
    check("beq_wrap", {12'b0, branch_target}, 32'hFFFFC);

    // JAL at 0x100, imm 0x20
    instruction = 32'h0200_00EF; PC = 20'h00100; #1;
    check("jal_target", {12'b0, JAL_target}, 32'h120);
    check("jal_npc", {30'b0, next_PC_sel}, 32'd2);
    check("jal_Asel", {30'b0, operand_A_sel}, 32'd2);
    check("jal_ALUOp", {29'b0, ALUOp}, 32'd3);
    ex_PC = 20'h00100;
    set_ex(3'b011, 3'b000, 7'h00, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0); #1;
    check("jal_link", ALU_result, 32'h104);

    // JALR target clears bit 0
    set_ex(3'b011, 3'b000, 7'h00, 2'b10, 1'b1, 32'h203, 32'd0, 32'd0); #1;
    check("jalr_target", {12'b0, JALR_target}, 32'h202);
    instruction = 32'h0000_8067; #1;   // jalr x0,0(x1)
    check("jalr_npc", {30'b0, next_PC_sel}, 32'd3);

    // LUI 0x12345
    instruction = 32'h1234_5137; #1;
    check("lui_imm", extend_imm, 32'h1234_5000);
    check("lui_Asel", {30'b0, operand_A_sel}, 32'd3);
    check("lui_ALUOp", {29'b0, ALUOp}, 32'd6);
    set_ex(3'b110, 3'b000, 7'h00, 2'b11, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000); #1;
    check("lui_result", ALU_result, 32'h1234_5000);

    // AUIPC: A = PC
    ex_PC = 20'h00200;
    set_ex(3'b110, 3'b000, 7'h00, 2'b01, 1'b1, 32'd0, 32'd0, 32'h0000_1000); #1;
    check("auipc_result", ALU_result, 32'h1200);

    // Store sw x2,4(x1) and negative S immediate
    instruction = 32'h0020_A223; #1;
    check("sw_imm", extend_imm, 32'd4);
    check("sw_memWrite", {31'b0, memWrite}, 32'd1);
    check("sw_regWrite", {31'b0, regWrite}, 32'd0);
    instruction = 32'hFE00_0FA3; #1;
    check("sw_neg_imm", extend_imm, 32'hFFFF_FFFF);

    // Load lw x1,0(x1)
    instruction = 32'h0000_A083; #1;
    check("lw_ctrl", {28'b0, memRead, memtoReg, regWrite, memWrite}, 32'b1110);
    check("lw_ALUOp", {29'b0, ALUOp}, 32'd4);

    // Unknown opcode -> all control zero
    instruction = 32'h0000_007F; #1;
    check("unknown_ctrl", {17'b0, branch_op, memRead, memtoReg, memWrite, regWrite,
                           ALUOp, next_PC_sel, operand_A_sel, operand_B_sel, extend_sel}, 32'd0);

    // Mid-operation reset clears x7, writes ignored while low
    instruction = 32'h0070_0013;       // rs2 = x7
    @(negedge clock); write = 1'b1; write_reg = 5'd7; write_data = 32'hAA;
    @(negedge clock); write = 1'b0; #1;
    check("x7_written", rs2_data, 32'hAA);
    #2 reset = 1'b0; #1;
    check("x7_async_clear", rs2_data, 32'h0);
    write = 1'b1; write_data = 32'h55;
    @(negedge clock); #1;
    check("x7_write_in_reset", rs2_data, 32'h0);
    write = 1'b0; reset = 1'b1; #1;
    check("x7_after_reset", rs2_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
